// File: rtl/definitions_pkg.sv
`default_nettype none
// ============================================================================
// Module   : definitions_pkg
// Brief    : Shared RV32I decode types, opcodes and operand-use helper.
// Revision : 1.0
// ============================================================================
package definitions_pkg;

    typedef enum logic [3:0] {
        ALU_ADD   = 4'd0,
        ALU_SUB   = 4'd1,
        ALU_SLL   = 4'd2,
        ALU_SLT   = 4'd3,
        ALU_SLTU  = 4'd4,
        ALU_XOR   = 4'd5,
        ALU_SRL   = 4'd6,
        ALU_SRA   = 4'd7,
        ALU_OR    = 4'd8,
        ALU_AND   = 4'd9,
        ALU_PASSB = 4'd10
    } alu_e;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_J    = 3'd4,
        IMM_U    = 3'd5
    } imm_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam int ID_XLEN = 32;
    localparam int ID_AW   = 5;

    // Default-width view of the decoded bundle.
    typedef struct packed {
        logic [ID_XLEN-1:0] pc;
        logic [ID_XLEN-1:0] imm;
        logic [ID_XLEN-1:0] rs1;
        logic [ID_XLEN-1:0] rs2;
        logic [ID_AW-1:0]   rd;
        alu_e               alu_sel;
    } id_bundle_t;

    // Returns {use_rs1, use_rs2}; unknown opcodes read nothing.
    function automatic logic [1:0] uses_rs(input logic [6:0] opcode);
        case (opcode)
            OPC_OP, OPC_STORE, OPC_BRANCH: uses_rs = 2'b11;
            OPC_JALR, OPC_LOAD, OPC_OPIMM: uses_rs = 2'b10;
            default:                       uses_rs = 2'b00;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module   : id_hazard_unit
// Brief    : Load-use hazard detect and WB->ID write-through operand bypass.
// Revision : 1.0
// ============================================================================
module id_hazard_unit #(
    parameter int XLEN      = 32,
    parameter int AW        = 5,
    parameter int BYPASS_EN = 1
) (
    input  logic            in_valid,
    input  logic            use_rs1,
    input  logic            use_rs2,
    input  logic [AW-1:0]   rs1_addr,
    input  logic [AW-1:0]   rs2_addr,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_rd,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic [XLEN-1:0] rf_rs1,
    input  logic [XLEN-1:0] rf_rs2,
    output logic            hz,
    output logic [XLEN-1:0] op1,
    output logic [XLEN-1:0] op2
);

    assign hz = in_valid & ex_is_load & (ex_rd != '0) &
                ((use_rs1 & (rs1_addr == ex_rd)) | (use_rs2 & (rs2_addr == ex_rd)));

    generate
        if (BYPASS_EN != 0) begin : g_bypass
            assign op1 = (wb_en && (wb_addr == rs1_addr) && (rs1_addr != '0)) ? wb_data : rf_rs1;
            assign op2 = (wb_en && (wb_addr == rs2_addr) && (rs2_addr != '0)) ? wb_data : rf_rs2;
        end else begin : g_no_bypass
            logic unused_wb;
            assign unused_wb = ^{wb_en, wb_addr, wb_data};
            assign op1 = rf_rs1;
            assign op2 = rf_rs2;
        end
    endgenerate

endmodule
`default_nettype wire

// File: rtl/inst_decode.sv
`default_nettype none
// ============================================================================
// Module   : inst_decode
// Brief    : RV32I field extraction, immediate generation and ALU select.
// Revision : 1.0
// ============================================================================
module inst_decode
    import definitions_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     inst,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic            use_rs1,
    output logic            use_rs2,
    output logic [XLEN-1:0] imm,
    output alu_e            alu_sel
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [31:0] imm32;
    logic        rd_wr;
    imm_e        imm_sel;

    function automatic alu_e alu_from_funct(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_funct = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_funct = ALU_SLL;
            3'b010:  alu_from_funct = ALU_SLT;
            3'b011:  alu_from_funct = ALU_SLTU;
            3'b100:  alu_from_funct = ALU_XOR;
            3'b101:  alu_from_funct = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_funct = ALU_OR;
            default: alu_from_funct = ALU_AND;
        endcase
    endfunction

    assign opcode             = inst[6:0];
    assign funct3             = inst[14:12];
    assign rs1                = inst[19:15];
    assign rs2                = inst[24:20];
    assign {use_rs1, use_rs2} = uses_rs(opcode);

    always_comb begin
        imm_sel = IMM_NONE;
        alu_sel = ALU_ADD;
        rd_wr   = 1'b0;
        case (opcode)
            OPC_LUI:    begin imm_sel = IMM_U; alu_sel = ALU_PASSB; rd_wr = 1'b1; end
            OPC_AUIPC:  begin imm_sel = IMM_U; rd_wr = 1'b1; end
            OPC_JAL:    begin imm_sel = IMM_J; rd_wr = 1'b1; end
            OPC_JALR:   begin imm_sel = IMM_I; rd_wr = 1'b1; end
            OPC_BRANCH: begin imm_sel = IMM_B; alu_sel = ALU_SUB; end
            OPC_LOAD:   begin imm_sel = IMM_I; rd_wr = 1'b1; end
            OPC_STORE:  begin imm_sel = IMM_S; end
            // Bit 30 of an I-type only selects SRAI; for ADDI it is immediate data.
            OPC_OPIMM:  begin
                imm_sel = IMM_I;
                alu_sel = alu_from_funct(funct3, (funct3 == 3'b101) & inst[30]);
                rd_wr   = 1'b1;
            end
            OPC_OP:     begin alu_sel = alu_from_funct(funct3, inst[30]); rd_wr = 1'b1; end
            default:    ;
        endcase
    end

    always_comb begin
        case (imm_sel)
            IMM_I:   imm32 = {{20{inst[31]}}, inst[31:20]};
            IMM_S:   imm32 = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   imm32 = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_J:   imm32 = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            IMM_U:   imm32 = {inst[31:12], 12'b0};
            default: imm32 = '0;
        endcase
    end

    assign imm = XLEN'(signed'(imm32));
    assign rd  = rd_wr ? inst[11:7] : 5'd0;

endmodule
`default_nettype wire

// File: rtl/register_file.sv
`default_nettype none
// ============================================================================
// Module   : register_file
// Brief    : Reset-free 2R1W register file; x0 reads zero, writes to x0 drop.
// Revision : 1.0
// ============================================================================
module register_file #(
    parameter  int XLEN  = 32,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] mem [NREGS];

    always_ff @(posedge clk) begin
        if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata1 = (raddr1 == '0) ? '0 : mem[raddr1];
    assign rdata2 = (raddr2 == '0) ? '0 : mem[raddr2];

endmodule
`default_nettype wire

// File: rtl/id_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : id_pipe_stage
// Brief    : Registered decode stage with RF read, bypass, load-use stall, flush.
// Revision : 1.0
// ============================================================================
module id_pipe_stage
    import definitions_pkg::*;
#(
    parameter  int XLEN      = 32,
    parameter  int NREGS     = 32,
    parameter  int BYPASS_EN = 1,
    localparam int AW        = $clog2(NREGS)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_inst,
    input  logic [XLEN-1:0] in_pc,
    input  logic            wb_en,
    input  logic [AW-1:0]   wb_addr,
    input  logic [XLEN-1:0] wb_data,
    input  logic            ex_is_load,
    input  logic [AW-1:0]   ex_rd,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_imm,
    output logic [XLEN-1:0] out_rs1,
    output logic [XLEN-1:0] out_rs2,
    output logic [AW-1:0]   out_rd,
    output alu_e            out_alu_sel
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] rs1;
        logic [XLEN-1:0] rs2;
        logic [AW-1:0]   rd;
        alu_e            alu_sel;
    } bundle_t;

    logic [4:0]      dec_rs1, dec_rs2, dec_rd;
    logic            use_rs1, use_rs2;
    logic [XLEN-1:0] dec_imm;
    alu_e            dec_alu;
    logic [XLEN-1:0] rf_rs1, rf_rs2, op1, op2;
    logic            hz, adv;
    bundle_t         bundle_q;

    inst_decode #(.XLEN(XLEN)) u_decode (
        .inst    (in_inst),
        .rs1     (dec_rs1),
        .rs2     (dec_rs2),
        .rd      (dec_rd),
        .use_rs1 (use_rs1),
        .use_rs2 (use_rs2),
        .imm     (dec_imm),
        .alu_sel (dec_alu)
    );

    register_file #(.XLEN(XLEN), .NREGS(NREGS)) u_rf (
        .clk    (clk),
        .we     (wb_en),
        .waddr  (wb_addr),
        .wdata  (wb_data),
        .raddr1 (AW'(dec_rs1)),
        .raddr2 (AW'(dec_rs2)),
        .rdata1 (rf_rs1),
        .rdata2 (rf_rs2)
    );

    id_hazard_unit #(.XLEN(XLEN), .AW(AW), .BYPASS_EN(BYPASS_EN)) u_hazard (
        .in_valid   (in_valid),
        .use_rs1    (use_rs1),
        .use_rs2    (use_rs2),
        .rs1_addr   (AW'(dec_rs1)),
        .rs2_addr   (AW'(dec_rs2)),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .rf_rs1     (rf_rs1),
        .rf_rs2     (rf_rs2),
        .hz         (hz),
        .op1        (op1),
        .op2        (op2)
    );

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv & ~hz & ~flush;

    // Flush beats both stall and advance; the bundle only loads on a real transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            bundle_q  <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (adv) begin
            if (hz) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= in_valid;
                if (in_valid) begin
                    bundle_q <= '{pc: in_pc, imm: dec_imm, rs1: op1, rs2: op2,
                                  rd: AW'(dec_rd), alu_sel: dec_alu};
                end
            end
        end
    end

    assign out_pc      = bundle_q.pc;
    assign out_imm     = bundle_q.imm;
    assign out_rs1     = bundle_q.rs1;
    assign out_rs2     = bundle_q.rs2;
    assign out_rd      = bundle_q.rd;
    assign out_alu_sel = bundle_q.alu_sel;

endmodule
`default_nettype wire

// File: tb/tb_id_pipe_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_id_pipe_stage
// Brief    : Directed plus randomized bench with a transaction-level model.
// Revision : 1.0
// ============================================================================
module tb_id_pipe_stage;
    import definitions_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0, in_ready;
    logic [31:0] in_inst = '0, in_pc = '0;
    logic        wb_en = 1'b0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        ex_is_load = 1'b0;
    logic [4:0]  ex_rd = '0;
    logic        flush = 1'b0;
    logic        out_valid, out_ready = 1'b1;
    logic [31:0] out_pc, out_imm, out_rs1, out_rs2;
    logic [4:0]  out_rd;
    alu_e        out_alu_sel;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    id_pipe_stage #(.XLEN(32), .NREGS(32), .BYPASS_EN(1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .wb_en(wb_en), .wb_addr(wb_addr),
        .wb_data(wb_data), .ex_is_load(ex_is_load), .ex_rd(ex_rd), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
        .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
        .out_alu_sel(out_alu_sel)
    );

    typedef struct {
        logic [31:0] imm;
        logic [4:0]  rd;
        alu_e        alu;
        bit          u1;
        bit          u2;
    } dec_t;

    logic [31:0] regs [32];
    bit          m_valid = 1'b0;
    id_bundle_t  m_b;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Sign-extend the low n bits of v.
    function automatic logic [31:0] sext(input int n, input logic [31:0] v);
        logic [31:0] m;
        m = v & ((32'd1 << n) - 32'd1);
        return m[n-1] ? m - (32'd1 << n) : m;
    endfunction

    function automatic dec_t ref_decode(input logic [31:0] inst);
        dec_t d;
        logic [2:0] f3;
        bit b30;
        f3  = inst[14:12];
        b30 = inst[30];
        d   = '{imm: 32'd0, rd: 5'd0, alu: ALU_ADD, u1: 1'b0, u2: 1'b0};
        case (inst[6:0])
            7'h37: begin d.imm = inst & 32'hFFFF_F000; d.rd = inst[11:7]; d.alu = ALU_PASSB; end
            7'h17: begin d.imm = inst & 32'hFFFF_F000; d.rd = inst[11:7]; end
            7'h6F: begin
                d.imm = sext(21, {11'd0, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0});
                d.rd  = inst[11:7];
            end
            7'h67: begin d.imm = sext(12, 32'(inst[31:20])); d.rd = inst[11:7]; d.u1 = 1; end
            7'h63: begin
                d.imm = sext(13, {19'd0, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0});
                d.alu = ALU_SUB; d.u1 = 1; d.u2 = 1;
            end
            7'h03: begin d.imm = sext(12, 32'(inst[31:20])); d.rd = inst[11:7]; d.u1 = 1; end
            7'h23: begin d.imm = sext(12, {20'd0, inst[31:25], inst[11:7]}); d.u1 = 1; d.u2 = 1; end
            7'h13, 7'h33: begin
                alu_e tbl [8];
                tbl = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
                d.alu = tbl[f3];
                if (f3 == 3'd5 && b30) d.alu = ALU_SRA;
                if (inst[6:0] == 7'h33 && f3 == 3'd0 && b30) d.alu = ALU_SUB;
                if (inst[6:0] == 7'h13) d.imm = sext(12, 32'(inst[31:20]));
                else d.u2 = 1;
                d.rd = inst[11:7]; d.u1 = 1;
            end
            default: ;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] idx);
        if (idx == 5'd0) return 32'd0;
        if (wb_en && wb_addr == idx) return wb_data;
        return regs[idx];
    endfunction

    function automatic bit exp_in_ready();
        dec_t d;
        bit hz;
        d  = ref_decode(in_inst);
        hz = in_valid && ex_is_load && ex_rd != 0 &&
             ((d.u1 && in_inst[19:15] == ex_rd) || (d.u2 && in_inst[24:20] == ex_rd));
        return (!m_valid || out_ready) && !hz && !flush;
    endfunction

    // Transaction-level model: an accepted instruction becomes the held bundle;
    // a consumed or flushed bundle disappears.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid = 1'b0;
            m_b     = '0;
        end else begin
            bit accepted, consumed;
            dec_t d;
            accepted = in_valid && exp_in_ready();
            consumed = m_valid && out_ready;
            if (accepted) begin
                d = ref_decode(in_inst);
                m_b = '{pc: in_pc, imm: d.imm, rs1: operand(in_inst[19:15]),
                        rs2: operand(in_inst[24:20]), rd: d.rd, alu_sel: d.alu};
                m_valid = 1'b1;
            end else if (consumed || flush) begin
                m_valid = 1'b0;
            end
            if (wb_en && wb_addr != 0) regs[wb_addr] = wb_data;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("in_ready", 64'(in_ready), 64'(exp_in_ready()));
            if (m_valid) begin
                check("out_pc", 64'(out_pc), 64'(m_b.pc));
                check("out_imm", 64'(out_imm), 64'(m_b.imm));
                check("out_rs1", 64'(out_rs1), 64'(m_b.rs1));
                check("out_rs2", 64'(out_rs2), 64'(m_b.rs2));
                check("out_rd", 64'(out_rd), 64'(m_b.rd));
                check("out_alu_sel", 64'(out_alu_sel), 64'(m_b.alu_sel));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9];
        logic [31:0] w;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33};
        w = $urandom;
        w[6:0]   = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 8)];
        w[19:15] = 5'($urandom_range(0, 7));
        w[24:20] = 5'($urandom_range(0, 7));
        return w;
    endfunction

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_out_pc", 64'(out_pc), 64'd0);
        check("reset_out_alu", 64'(out_alu_sel), 64'(ALU_ADD));

        for (int i = 1; i < 32; i++) begin
            wb_en = 1'b1; wb_addr = 5'(i); wb_data = $urandom;
            cyc();
        end
        wb_en = 1'b0;

        // addi x1, x0, 5
        present(32'h0050_0093, 32'h100);
        #1 check("basic_in_ready", 64'(in_ready), 64'd1);
        cyc();
        check("basic_valid", 64'(out_valid), 64'd1);
        check("basic_imm", 64'(out_imm), 64'd5);
        check("basic_rd", 64'(out_rd), 64'd1);
        check("basic_rs1", 64'(out_rs1), 64'd0);
        check("basic_pc", 64'(out_pc), 64'h100);

        // add x3, x2, x0 with same-cycle write of x2
        present(32'h0001_01B3, 32'h104);
        wb_en = 1'b1; wb_addr = 5'd2; wb_data = 32'hDEAD_BEEF;
        cyc();
        check("bypass_rs1", 64'(out_rs1), 64'hDEAD_BEEF);
        check("bypass_rs2", 64'(out_rs2), 64'd0);
        check("bypass_rd", 64'(out_rd), 64'd3);

        in_valid = 1'b0; wb_addr = 5'd0; wb_data = 32'h1234;
        cyc();
        wb_en = 1'b0;
        present(32'h0000_01B3, 32'h108);
        cyc();
        check("x0_rs1", 64'(out_rs1), 64'd0);
        check("x0_rs2", 64'(out_rs2), 64'd0);

        present(32'h0001_01B3, 32'h180);
        ex_is_load = 1'b1; ex_rd = 5'd2;
        #1 check("loaduse_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("loaduse_bubble", 64'(out_valid), 64'd0);
        ex_is_load = 1'b0;
        #1 check("loaduse_retry_ready", 64'(in_ready), 64'd1);
        cyc();
        check("loaduse_accept", 64'(out_valid), 64'd1);
        check("loaduse_rs1", 64'(out_rs1), 64'hDEAD_BEEF);

        out_ready = 1'b0;
        present(32'h0050_0093, 32'h200);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_in_ready", 64'(in_ready), 64'd0);
            cyc();
            check("bp_valid", 64'(out_valid), 64'd1);
            check("bp_pc", 64'(out_pc), 64'h180);
            check("bp_rs1", 64'(out_rs1), 64'hDEAD_BEEF);
        end
        out_ready = 1'b1;
        cyc();
        check("bp_release_pc", 64'(out_pc), 64'h200);

        out_ready = 1'b0;
        present(32'h0050_0093, 32'h300);
        flush = 1'b1;
        #1 check("flush_in_ready", 64'(in_ready), 64'd0);
        cyc();
        check("flush_valid", 64'(out_valid), 64'd0);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        cyc();
        check("flush_dropped", 64'(out_valid), 64'd0);

        present(32'h0050_0093, 32'h400);
        cyc();
        out_ready = 1'b0;
        #2 rst = 1'b1;
        #1 check("async_rst_valid", 64'(out_valid), 64'd0);
        check("async_rst_pc", 64'(out_pc), 64'd0);
        cyc();
        rst = 1'b0;
        out_ready = 1'b1;
        present(32'h0050_0093, 32'h500);
        cyc();
        check("post_rst_valid", 64'(out_valid), 64'd1);
        check("post_rst_pc", 64'(out_pc), 64'h500);
        check("post_rst_imm", 64'(out_imm), 64'd5);

        for (int n = 0; n < 3000; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            in_inst    = rand_inst();
            in_pc      = $urandom & 32'hFFFF_FFFC;
            out_ready  = ($urandom_range(0, 3) != 0);
            wb_en      = ($urandom_range(0, 1) != 0);
            wb_addr    = 5'($urandom_range(0, 7));
            wb_data    = $urandom;
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            flush      = ($urandom_range(0, 15) == 0);
            cyc();
        end
        in_valid = 1'b0; wb_en = 1'b0; flush = 1'b0;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
